// File: rtl/boss_pkg.sv
// rtl/boss_pkg.sv - shared state encoding and widths for the boss stage controller
package boss_pkg;

    localparam int HEALTH_WIDTH = 8;
    localparam int LFSR_WIDTH   = 16;

    typedef enum logic [2:0] {
        IDLE,
        ENTER,
        FIGHT,
        ENRAGED,
        DYING,
        DONE
    } boss_state_t;

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Fibonacci LFSR (taps 16,14,13,11), steps once per advance
module lfsr16 import boss_pkg::*; #(
    parameter logic [LFSR_WIDTH-1:0] SEED = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  advance,
    output logic [LFSR_WIDTH-1:0] out
);

    logic feedback;

    assign feedback = out[15] ^ out[13] ^ out[12] ^ out[10];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            out <= SEED;
        end else if (advance) begin
            out <= {out[14:0], feedback};
        end
    end

endmodule

// File: rtl/boss_controller.sv
// rtl/boss_controller.sv - boss stage sequencer: phases, health, shot schedule, movement pulses
module boss_controller import boss_pkg::*; #(
    parameter int                    BOSS_HEALTH          = 16,
    parameter int                    ENRAGE_HEALTH        = 6,
    parameter int                    ENTER_FRAMES         = 60,
    parameter int                    SHOOT_PERIOD         = 45,
    parameter int                    ENRAGED_SHOOT_PERIOD = 20,
    parameter int                    DYING_FRAMES         = 90,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED            = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic                    boss_enable,
    input  logic                    boss_hit,
    output logic                    switch_direction_pulse,
    output logic                    random_axis,
    output logic                    shoot_pulse,
    output logic                    boss_visible,
    output logic                    boss_dying,
    output logic                    boss_defeated,
    output logic [HEALTH_WIDTH-1:0] health
);

    if (BOSS_HEALTH < 1 || BOSS_HEALTH > 255 || ENRAGE_HEALTH >= BOSS_HEALTH ||
        ENTER_FRAMES < 1 || ENTER_FRAMES > 255 || DYING_FRAMES < 1 || DYING_FRAMES > 255 ||
        SHOOT_PERIOD < 2 || SHOOT_PERIOD > 255 ||
        ENRAGED_SHOOT_PERIOD < 2 || ENRAGED_SHOOT_PERIOD > 255) begin : g_bad_params
        $error("boss_controller: parameter out of range");
    end

    localparam logic [7:0] HEALTH_INIT = 8'(BOSS_HEALTH);
    localparam logic [7:0] ENRAGE_LVL  = 8'(ENRAGE_HEALTH);
    localparam logic [7:0] ENTER_LAST  = 8'(ENTER_FRAMES - 1);
    localparam logic [7:0] SHOOT_LAST  = 8'(SHOOT_PERIOD - 1);
    localparam logic [7:0] ENR_LAST    = 8'(ENRAGED_SHOOT_PERIOD - 1);
    localparam logic [7:0] DYING_LAST  = 8'(DYING_FRAMES - 1);

    boss_state_t                   state, state_nxt;
    logic [HEALTH_WIDTH-1:0]       health_nxt, health_dec;
    logic [7:0]                    frame_cnt, frame_nxt, shot_cnt, shot_nxt, shot_last;
    logic                          shoot_nxt, axis_nxt;
    logic [LFSR_WIDTH-1:0]         lfsr_q;
    logic                          unused_lfsr_bits;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .resetN  (resetN),
        .advance (startOfFrame && (state != IDLE)),
        .out     (lfsr_q)
    );

    assign unused_lfsr_bits = ^lfsr_q[15:1];

    always_comb begin
        state_nxt  = state;
        health_nxt = health;
        frame_nxt  = frame_cnt;
        shot_nxt   = shot_cnt;
        shoot_nxt  = 1'b0;
        axis_nxt   = random_axis;
        health_dec = (health == '0) ? '0 : health - 1'b1;
        shot_last  = (state == ENRAGED) ? ENR_LAST : SHOOT_LAST;

        if (state != IDLE && !boss_enable) begin
            state_nxt  = IDLE;
            health_nxt = HEALTH_INIT;
            frame_nxt  = '0;
            shot_nxt   = '0;
            axis_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (boss_enable) begin
                        state_nxt  = ENTER;
                        frame_nxt  = '0;
                        health_nxt = HEALTH_INIT;
                    end
                end
                ENTER: begin
                    if (startOfFrame) begin
                        if (frame_cnt == ENTER_LAST) begin
                            state_nxt = FIGHT;
                            frame_nxt = '0;
                            shot_nxt  = '0;
                        end else begin
                            frame_nxt = frame_cnt + 8'd1;
                        end
                    end
                end
                FIGHT, ENRAGED: begin
                    if (startOfFrame) begin
                        if (shot_cnt == shot_last) begin
                            shoot_nxt = 1'b1;
                            axis_nxt  = lfsr_q[0];
                            shot_nxt  = '0;
                        end else begin
                            shot_nxt = shot_cnt + 8'd1;
                        end
                    end
                    // The shot above still fires even if this hit ends the fight.
                    if (boss_hit) begin
                        health_nxt = health_dec;
                        if (health_dec == '0) begin
                            state_nxt = DYING;
                            frame_nxt = '0;
                        end else if (state == FIGHT && health_dec <= ENRAGE_LVL) begin
                            state_nxt = ENRAGED;
                            shot_nxt  = '0;
                        end
                    end
                end
                DYING: begin
                    if (startOfFrame) begin
                        if (frame_cnt == DYING_LAST) begin
                            state_nxt = DONE;
                            frame_nxt = '0;
                        end else begin
                            frame_nxt = frame_cnt + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state                  <= IDLE;
            health                 <= HEALTH_INIT;
            frame_cnt              <= '0;
            shot_cnt               <= '0;
            shoot_pulse            <= 1'b0;
            switch_direction_pulse <= 1'b0;
            random_axis            <= 1'b0;
            boss_visible           <= 1'b0;
            boss_dying             <= 1'b0;
            boss_defeated          <= 1'b0;
        end else begin
            state                  <= state_nxt;
            health                 <= health_nxt;
            frame_cnt              <= frame_nxt;
            shot_cnt               <= shot_nxt;
            shoot_pulse            <= shoot_nxt;
            switch_direction_pulse <= shoot_nxt;
            random_axis            <= axis_nxt;
            boss_visible           <= (state_nxt == ENTER) || (state_nxt == FIGHT) ||
                                      (state_nxt == ENRAGED) || (state_nxt == DYING);
            boss_dying             <= (state_nxt == DYING);
            boss_defeated          <= (state_nxt == DONE) && (state != DONE);
        end
    end

endmodule
